// File: rtl/data_ram_dp.sv
// rtl/data_ram_dp.sv - dual-port data RAM (A read/write, B read-only) with self-clearing engine
module data_ram_dp #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 8,
  parameter int                OUT_REG   = 0,
  parameter int                RDW_MODE  = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                a_en,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_din,
  output logic [DATA_W-1:0]   a_dout,
  output logic                a_valid,
  input  logic                b_en,
  input  logic [ADDR_W-1:0]   b_addr,
  output logic [DATA_W-1:0]   b_dout,
  output logic                b_valid,
  input  logic                init_req,
  output logic                init_busy
);

  localparam int              DEPTH  = 1 << ADDR_W;
  localparam int              NBYTES = DATA_W / 8;
  // cnt is one bit wider than the address so it never wraps at the terminal count
  localparam logic [ADDR_W:0] LAST   = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W:0]     w_cnt_nxt;
  logic                w_clr_we;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_idle;
  logic                w_a_acc;
  logic                w_a_wr;
  logic                w_b_acc;
  logic [DATA_W-1:0]   w_a_old;
  logic [DATA_W-1:0]   w_b_old;
  logic [DATA_W-1:0]   w_a_new;
  logic [DATA_W-1:0]   w_a_rdata;

  logic                r_a_v1;
  logic [DATA_W-1:0]   r_a_d1;
  logic                r_b_v1;
  logic [DATA_W-1:0]   r_b_d1;

  // user accesses are only honoured outside the clear sweep
  assign w_idle    = (r_state == ST_IDLE);
  assign w_a_acc   = w_idle & a_en;
  assign w_a_wr    = w_a_acc & a_we;
  assign w_b_acc   = w_idle & b_en;
  assign init_busy = (r_state == ST_CLEAR);

  // asynchronous array reads; port B always sees the pre-write word
  assign w_a_old   = r_mem[a_addr];
  assign w_b_old   = r_mem[b_addr];
  assign w_a_rdata = (RDW_MODE != 0) ? w_a_new : w_a_old;

  // byte-lane merge of port A write data into the stored word
  always_comb begin
    w_a_new = w_a_old;
    for (int i = 0; i < NBYTES; i++) begin
      if (a_be[i]) begin
        w_a_new[8*i +: 8] = a_din[8*i +: 8];
      end
    end
  end

  // clear FSM next-state: sweep every address once, then wait for init_req
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + (ADDR_W + 1)'(1);
        if (r_cnt == LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (init_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // clear FSM state register; reset restarts the sweep at address 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // array write port, shared by the clear engine and port A (never both at once)
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt[ADDR_W-1:0]] <= CLEAR_VAL;
    end else if (w_a_wr) begin
      r_mem[a_addr] <= w_a_new;
    end
  end

  // first read stage; data only loads on an access so outputs hold between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_v1 <= 1'b0;
      r_a_d1 <= '0;
      r_b_v1 <= 1'b0;
      r_b_d1 <= '0;
    end else begin
      r_a_v1 <= w_a_acc;
      r_b_v1 <= w_b_acc;
      if (w_a_acc) begin
        r_a_d1 <= w_a_rdata;
      end
      if (w_b_acc) begin
        r_b_d1 <= w_b_old;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              r_a_v2;
      logic [DATA_W-1:0] r_a_d2;
      logic              r_b_v2;
      logic [DATA_W-1:0] r_b_d2;

      // optional second stage for timing; same hold-on-idle behaviour
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_a_v2 <= 1'b0;
          r_a_d2 <= '0;
          r_b_v2 <= 1'b0;
          r_b_d2 <= '0;
        end else begin
          r_a_v2 <= r_a_v1;
          r_b_v2 <= r_b_v1;
          if (r_a_v1) begin
            r_a_d2 <= r_a_d1;
          end
          if (r_b_v1) begin
            r_b_d2 <= r_b_d1;
          end
        end
      end

      assign a_valid = r_a_v2;
      assign a_dout  = r_a_d2;
      assign b_valid = r_b_v2;
      assign b_dout  = r_b_d2;
    end else begin : g_no_out_reg
      assign a_valid = r_a_v1;
      assign a_dout  = r_a_d1;
      assign b_valid = r_b_v1;
      assign b_dout  = r_b_d1;
    end
  endgenerate

endmodule

// File: tb/tb_data_ram_dp.sv
// tb/tb_data_ram_dp.sv - scoreboard bench for data_ram_dp (two parameterisations)
module tb_data_ram_dp;

  typedef struct {
    logic [15:0] data;
    int          due;
  } sb_t;

  logic        clk;
  logic        reset_n;
  logic        a_en;
  logic        a_we;
  logic [1:0]  a_be;
  logic [7:0]  a_addr;
  logic [15:0] a_din;
  logic        b_en;
  logic [7:0]  b_addr;
  logic        init_req;

  logic [15:0] a_dout0, b_dout0, a_dout1, b_dout1;
  logic        a_valid0, b_valid0, a_valid1, b_valid1;
  logic        init_busy0, init_busy1;

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  sb_t         q [4][$];

  // dut0: defaults (1-cycle latency, old data); dut1: 2-cycle latency, new data
  data_ram_dp dut0 (
    .clk(clk), .reset_n(reset_n),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout0), .a_valid(a_valid0),
    .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout0), .b_valid(b_valid0),
    .init_req(init_req), .init_busy(init_busy0)
  );

  data_ram_dp #(.OUT_REG(1), .RDW_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout1), .a_valid(a_valid1),
    .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout1), .b_valid(b_valid1),
    .init_req(init_req), .init_busy(init_busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [15:0] d, input int lat);
    sb_t e;
    e.data = d;
    e.due  = cyc + lat;
    q[k].push_back(e);
  endtask

  task automatic mon(input int k, input logic v, input logic [15:0] d);
    sb_t e;
    if (v) begin
      if (q[k].size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb%0d_unexpected actual=valid data %h required=no valid", k, d);
      end else begin
        e = q[k].pop_front();
        chk($sformatf("sb%0d_data", k), 32'(d), 32'(e.data));
        chk($sformatf("sb%0d_cycle", k), cyc, e.due);
      end
    end
  endtask

  // monitor: 0=dut0 A, 1=dut0 B, 2=dut1 A, 3=dut1 B
  always @(negedge clk) begin
    mon(0, a_valid0, a_dout0);
    mon(1, b_valid0, b_dout0);
    mon(2, a_valid1, a_dout1);
    mon(3, b_valid1, b_dout1);
  end

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0; a_be = 2'b00; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_addr = '0; init_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic a_rd(input logic [7:0] ad, input logic [15:0] exp);
    a_en = 1'b1; a_we = 1'b0; a_addr = ad;
    push(0, exp, 1);
    push(2, exp, 2);
  endtask

  task automatic a_wr(input logic [7:0] ad, input logic [15:0] d, input logic [1:0] be,
                      input logic [15:0] e_old, input logic [15:0] e_new);
    a_en = 1'b1; a_we = 1'b1; a_addr = ad; a_din = d; a_be = be;
    push(0, e_old, 1);
    push(2, e_new, 2);
  endtask

  task automatic b_rd(input logic [7:0] ad, input logic [15:0] exp);
    b_en = 1'b1; b_addr = ad;
    push(1, exp, 1);
    push(3, exp, 2);
  endtask

  task automatic wait_clear(input string nm);
    int n0 = 0;
    int n1 = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!init_busy0 && !init_busy1) break;
      n0 += int'(init_busy0);
      n1 += int'(init_busy1);
    end
    chk({nm, "_busy0"}, n0, 256);
    chk({nm, "_busy1"}, n1, 256);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n1;
    idle();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy0", 32'(init_busy0), 1);
    chk("rst_busy1", 32'(init_busy1), 1);
    chk("rst_valid", {28'd0, a_valid0, b_valid0, a_valid1, b_valid1}, 0);
    chk("rst_dout0", {a_dout0, b_dout0}, 0);
    chk("rst_dout1", {a_dout1, b_dout1}, 0);
    reset_n = 1'b1;
    wait_clear("clr_init");

    // cleared array, both ports back-to-back
    @(posedge clk); #1;
    a_rd(8'h00, 16'h0000); b_rd(8'h7F, 16'h0000); tick();
    a_rd(8'hFF, 16'h0000); b_rd(8'h00, 16'h0000); tick();

    // back-to-back writes then reads for latency and throughput
    a_wr(8'h01, 16'h1111, 2'b11, 16'h0000, 16'h1111); tick();
    a_wr(8'h02, 16'h2222, 2'b11, 16'h0000, 16'h2222); tick();
    a_wr(8'h03, 16'h3333, 2'b11, 16'h0000, 16'h3333); tick();
    a_rd(8'h01, 16'h1111); tick();
    a_rd(8'h02, 16'h2222); tick();
    a_rd(8'h03, 16'h3333); tick();

    // byte-lane enables
    a_wr(8'h10, 16'h00FF, 2'b11, 16'h0000, 16'h00FF); tick();
    a_wr(8'h10, 16'hAB12, 2'b10, 16'h00FF, 16'hABFF); tick();
    a_wr(8'h10, 16'h1234, 2'b00, 16'hABFF, 16'hABFF); tick();
    a_rd(8'h10, 16'hABFF); b_rd(8'h10, 16'hABFF); tick();
    a_wr(8'h10, 16'h00CD, 2'b01, 16'hABFF, 16'hABCD); tick();
    b_rd(8'h10, 16'hABCD); tick();

    // same-address write on A with read on B
    a_wr(8'h20, 16'h5555, 2'b11, 16'h0000, 16'h5555); tick();
    a_wr(8'h20, 16'h1234, 2'b11, 16'h5555, 16'h1234); b_rd(8'h20, 16'h5555); tick();
    b_rd(8'h20, 16'h1234); tick();

    // re-clear: access sharing the init_req cycle wins, requests during clear are dropped
    a_wr(8'h40, 16'hBEEF, 2'b11, 16'h0000, 16'hBEEF); tick();
    a_rd(8'h40, 16'hBEEF); init_req = 1'b1; tick();
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!init_busy0 && !init_busy1) break;
      n0 += int'(init_busy0);
      n1 += int'(init_busy1);
      if (i < 10 || i == 200) begin
        a_en = 1'b1; a_we = 1'b1; a_be = 2'b11; a_addr = 8'h40; a_din = 16'h1111;
        b_en = 1'b1; b_addr = 8'h40; init_req = 1'b1;
      end else begin
        idle();
      end
    end
    idle();
    chk("clr_req_busy0", n0, 256);
    chk("clr_req_busy1", n1, 256);
    a_rd(8'h40, 16'h0000); b_rd(8'h40, 16'h0000); tick();

    // reset in the middle of a clear
    a_wr(8'h50, 16'h7777, 2'b11, 16'h0000, 16'h7777); tick();
    a_rd(8'h50, 16'h7777); b_rd(8'h50, 16'h7777); tick();
    tick(); tick();
    chk("hold_a0", 32'(a_dout0), 32'h7777);
    chk("hold_b1", 32'(b_dout1), 32'h7777);
    init_req = 1'b1; tick();
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {30'd0, init_busy0, init_busy1}, 3);
    chk("mid_rst_dout0", {a_dout0, b_dout0}, 0);
    chk("mid_rst_dout1", {a_dout1, b_dout1}, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_clear("clr_restart");
    @(posedge clk); #1;
    a_rd(8'h50, 16'h0000); b_rd(8'h50, 16'h0000); tick();
    a_rd(8'h00, 16'h0000); tick();

    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sb%0d_drain", k), q[k].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_ram_dp.md
DATA_RAM_DP -- requirements
Module: data_ram_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter OUT_REG, default 0, 0 = 1-cycle read latency, 1 = 2-cycle read latency (extra output register).
REQ-004 SHALL have parameter RDW_MODE, default 0, port A same-address read-during-write: 0 = old data, 1 = new (merged) data.
REQ-005 SHALL have parameter CLEAR_VAL, default 0, DATA_W-bit value written by the clear engine.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port a_en  input  1  port A access request.
REQ-009 SHALL have port a_we  input  1  port A write when a_en=1; read otherwise.
REQ-010 SHALL have port a_be  input  DATA_W/8  port A byte-lane write enables.
REQ-011 SHALL have port a_addr  input  ADDR_W  port A address.
REQ-012 SHALL have port a_din  input  DATA_W  port A write data.
REQ-013 SHALL have port a_dout  output  DATA_W  port A read data.
REQ-014 SHALL have port a_valid  output  1  a_dout holds data for a completed port A access.
REQ-015 SHALL have port b_en  input  1  port B read request (read-only port).
REQ-016 SHALL have port b_addr  input  ADDR_W  port B address.
REQ-017 SHALL have port b_dout  output  DATA_W  port B read data.
REQ-018 SHALL have port b_valid  output  1  b_dout holds data for a completed port B read.
REQ-019 SHALL have port init_req  input  1  single-cycle request to re-clear the whole array.
REQ-020 SHALL have port init_busy  output  1  clear engine active; user accesses are ignored.

Function
REQ-021 Clear FSM SHALL have states CLEAR and IDLE: CLEAR writes CLEAR_VAL to address cnt and increments cnt by 1 per cycle; CLEAR -> IDLE after the write to address DEPTH-1; IDLE -> CLEAR on init_req=1 with cnt reset to 0.
REQ-022 init_busy SHALL equal 1 exactly while the FSM is in CLEAR; one full clear SHALL take DEPTH cycles.
REQ-023 While init_busy=1: a_en/b_en SHALL be ignored, writes SHALL be dropped, a_valid/b_valid SHALL be 0, and init_req SHALL be ignored.
REQ-024 In IDLE, a port A write (a_en=1, a_we=1) SHALL update only the byte lanes i where a_be[i]=1; a_be=0 SHALL leave the word unchanged.
REQ-025 A port A write SHALL also produce a read of that address: a_dout = old word (RDW_MODE=0) or merged new word (RDW_MODE=1), with a_valid asserted.
REQ-026 A read on either port SHALL present data and assert *_valid for exactly one cycle, 1 cycle after the request (OUT_REG=0) or 2 cycles after (OUT_REG=1); back-to-back requests SHALL give back-to-back results at full throughput.
REQ-027 *_dout SHALL hold its last value when *_valid=0.
REQ-028 A port B read of the address port A writes in the same cycle SHALL return the old word regardless of RDW_MODE.
REQ-029 Addresses SHALL be full range 0..DEPTH-1 with no wrap or out-of-range case; cnt SHALL be ADDR_W+1 bits or detect terminal count without overflow.
REQ-030 init_req arriving in the same cycle as a user access in IDLE SHALL give the access priority in that cycle; CLEAR SHALL begin on the next cycle.

Reset
REQ-031 reset_n=0 SHALL asynchronously force: FSM = CLEAR, cnt = 0, init_busy = 1, a_valid = b_valid = 0, a_dout = b_dout = 0, all pipeline registers = 0.
REQ-032 Array contents SHALL NOT be reset directly; the clear engine SHALL start at address 0 on the first clock edge after reset_n rises.
REQ-033 reset_n asserted mid-clear or mid-access SHALL abort the operation and restart the clear from address 0 after release.

Verification
REQ-034 Reset release, defaults -> init_busy=1 for 256 cycles then 0; reads of addr 0x00, 0x7F, 0xFF return 0x0000.
REQ-035 A write 0x00FF to 0x10 with be=2'b11, then write 0xAB12 with be=2'b10 -> read returns 0xABFF; be=2'b00 write leaves 0xABFF.
REQ-036 Same-cycle A write 0x1234 to 0x20 (old 0x5555) and B read 0x20 -> b_dout=0x5555; a_dout=0x5555 (RDW_MODE=0) or 0x1234 (RDW_MODE=1).
REQ-037 OUT_REG=1, A reads 0x01,0x02,0x03 on consecutive cycles -> a_valid high cycles 2,3,4 after the first request with matching data.
REQ-038 Fill 0x40 with 0xBEEF, pulse init_req -> init_busy high 256 cycles, requests during it give no valid, afterwards 0x40 reads CLEAR_VAL.
REQ-039 reset_n pulsed low at clear cycle 100 -> outputs zero immediately; full 256-cycle clear restarts from address 0.
